// File: rtl/axi_stream_pkg.sv
// Shared codes and FSM states for the AXI3 stream responder.
// Includes the burst legality check used by both address channels.
package axi_stream_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [2:0] SIZE4  = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rstate_t;

  // Window is contiguous, so first and last beat bound every beat.
  function automatic logic burst_ok(
    input logic [31:0] addr,
    input logic [3:0]  len,
    input logic [1:0]  burst,
    input logic [2:0]  size,
    input logic [31:0] base,
    input logic [32:0] limit
  );
    logic [32:0] last;
    last = {1'b0, addr} + {27'd0, len, 2'b00};
    return (burst == INCR) && (size == SIZE4) &&
           (addr >= base) && (last < limit);
  endfunction

endpackage

// File: rtl/axi3_bram_responder_if.sv
// AXI3 32-bit / 6-bit-ID bus between the stream DMA and the responder.
// Cache/lock/prot/qos are carried but not used by the responder.
interface axi3_bram_responder_if;

  logic [31:0] awaddr;
  logic [1:0]  awburst;
  logic [5:0]  awid;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [3:0]  awcache;
  logic [1:0]  awlock;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [5:0]  wid;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [5:0]  arid;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [3:0]  arcache;
  logic [1:0]  arlock;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [5:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awburst, awid, awlen, awsize,
    input  awcache, awlock, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wid, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arburst, arid, arlen, arsize,
    input  arcache, arlock, arprot, arqos, arvalid,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awburst, awid, awlen, awsize,
    output awcache, awlock, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wid, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arburst, arid, arlen, arsize,
    output arcache, arlock, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_resp_ram.sv
// Simple dual-port RAM, byte-enabled write, registered read-first read.
// Read register can be forced to zero for errored read beats.
module axi_resp_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic              i_rclr,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_rclr) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axi3_bram_responder.sv
// AXI3 responder backing INCR bursts with an on-chip RAM window.
// Independent read/write FSMs, one outstanding burst each.
module axi3_bram_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h1E00_0000,
  parameter int          ADDR_W    = 12
) (
  input  logic                  AXI_clk,
  input  logic                  AXI_rst_n,
  axi3_bram_responder_if.slave  AXI,
  output logic [15:0]           err_cnt
);
  import axi_stream_pkg::*;

  localparam logic [32:0] LIMIT =
    {1'b0, ADDR_BASE} + (33'd4 << ADDR_W);

  wstate_t           r_wstate, w_wnext;
  logic [5:0]        r_awid;
  logic [3:0]        r_wlen, r_wbeat;
  logic [ADDR_W-1:0] r_widx;
  logic              r_wok, r_wbad;
  logic              r_awready, r_wready, r_bvalid;
  logic [1:0]        r_bresp;

  rstate_t           r_rstate, w_rnext;
  logic [5:0]        r_rid;
  logic [3:0]        r_rlen, r_rbeat;
  logic [ADDR_W-1:0] r_ridx;
  logic              r_rok;
  logic              r_arready, r_rvalid, r_rlast;
  logic [1:0]        r_rresp;
  logic [15:0]       r_errcnt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_wend, w_beat_bad, w_we;
  logic w_ar_hs, w_r_hs;
  logic [1:0]  w_einc;
  logic [16:0] w_esum;

  assign w_aw_hs    = r_awready & AXI.awvalid;
  assign w_w_hs     = r_wready & AXI.wvalid;
  assign w_b_hs     = r_bvalid & AXI.bready;
  assign w_wend     = (r_wbeat == r_wlen);
  assign w_beat_bad = (AXI.wid != r_awid) | (AXI.wlast != w_wend);
  assign w_we       = w_w_hs & r_wok & ~r_wbad & ~w_beat_bad;
  assign w_ar_hs    = r_arready & AXI.arvalid;
  assign w_r_hs     = r_rvalid & AXI.rready;

  always_comb begin
    w_wnext = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
      W_DATA:  if (w_w_hs && w_wend) w_wnext = W_RESP;
      W_RESP:  if (w_b_hs) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge AXI_clk or negedge AXI_rst_n) begin
    if (!AXI_rst_n) begin
      r_wstate  <= W_IDLE;
      r_awid    <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
      r_widx    <= '0;
      r_wok     <= 1'b0;
      r_wbad    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      r_wstate  <= w_wnext;
      r_awready <= (w_wnext == W_IDLE);
      r_wready  <= (w_wnext == W_DATA);
      r_bvalid  <= (w_wnext == W_RESP);
      if (w_aw_hs) begin
        r_awid  <= AXI.awid;
        r_wlen  <= AXI.awlen;
        r_wbeat <= '0;
        r_widx  <= ADDR_W'((AXI.awaddr - ADDR_BASE) >> 2);
        r_wok   <= burst_ok(AXI.awaddr, AXI.awlen, AXI.awburst,
                            AXI.awsize, ADDR_BASE, LIMIT);
        r_wbad  <= 1'b0;
      end
      if (w_w_hs) begin
        r_wbeat <= r_wbeat + 4'd1;
        if (w_beat_bad) r_wbad <= 1'b1;
        if (w_wend) begin
          r_bresp <= (r_wok & ~r_wbad & ~w_beat_bad) ? OKAY : SLVERR;
        end
      end
    end
  end

  always_comb begin
    w_rnext = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_FETCH;
      R_FETCH: w_rnext = R_DATA;
      R_DATA:  if (w_r_hs) w_rnext = r_rlast ? R_IDLE : R_FETCH;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge AXI_clk or negedge AXI_rst_n) begin
    if (!AXI_rst_n) begin
      r_rstate  <= R_IDLE;
      r_rid     <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
      r_ridx    <= '0;
      r_rok     <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= OKAY;
    end else begin
      r_rstate  <= w_rnext;
      r_arready <= (w_rnext == R_IDLE);
      r_rvalid  <= (w_rnext == R_DATA);
      r_rlast   <= (w_rnext == R_DATA) && (r_rbeat == r_rlen);
      if (w_ar_hs) begin
        r_rid   <= AXI.arid;
        r_rlen  <= AXI.arlen;
        r_rbeat <= '0;
        r_ridx  <= ADDR_W'((AXI.araddr - ADDR_BASE) >> 2);
        r_rok   <= burst_ok(AXI.araddr, AXI.arlen, AXI.arburst,
                            AXI.arsize, ADDR_BASE, LIMIT);
        r_rresp <= burst_ok(AXI.araddr, AXI.arlen, AXI.arburst,
                            AXI.arsize, ADDR_BASE, LIMIT) ? OKAY : SLVERR;
      end
      if (w_r_hs && !r_rlast) r_rbeat <= r_rbeat + 4'd1;
    end
  end

  // Both paths can finish an errored burst in the same cycle.
  assign w_einc = {1'b0, w_b_hs & (r_bresp == SLVERR)} +
                  {1'b0, w_r_hs & r_rlast & (r_rresp == SLVERR)};
  assign w_esum = {1'b0, r_errcnt} + {15'd0, w_einc};

  always_ff @(posedge AXI_clk or negedge AXI_rst_n) begin
    if (!AXI_rst_n) r_errcnt <= '0;
    else r_errcnt <= w_esum[16] ? 16'hFFFF : w_esum[15:0];
  end

  axi_resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (AXI_clk),
    .i_rst_n (AXI_rst_n),
    .i_we    (w_we),
    .i_be    (AXI.wstrb),
    .i_waddr (r_widx + ADDR_W'(r_wbeat)),
    .i_wdata (AXI.wdata),
    .i_re    ((r_rstate == R_FETCH) & r_rok),
    .i_rclr  ((r_rstate == R_FETCH) & ~r_rok),
    .i_raddr (r_ridx + ADDR_W'(r_rbeat)),
    .o_rdata (AXI.rdata)
  );

  assign AXI.awready = r_awready;
  assign AXI.wready  = r_wready;
  assign AXI.bvalid  = r_bvalid;
  assign AXI.bid     = r_awid;
  assign AXI.bresp   = r_bresp;
  assign AXI.arready = r_arready;
  assign AXI.rvalid  = r_rvalid;
  assign AXI.rid     = r_rid;
  assign AXI.rresp   = r_rresp;
  assign AXI.rlast   = r_rlast;
  assign err_cnt     = r_errcnt;

endmodule

// File: tb/tb_axi3_bram_responder.sv
// Scoreboard bench for axi3_bram_responder: word-array memory model,
// expected B/R responses queued at issue, popped by a negedge monitor.
module tb_axi3_bram_responder;
  import axi_stream_pkg::*;

  localparam logic [31:0] BASE = 32'h1E00_0000;
  localparam int AW = 12;
  localparam int NW = 1 << AW;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [31:0] d;
    bit          chk;
    logic [5:0]  id;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] err_cnt;

  axi3_bram_responder_if axi();

  axi3_bram_responder #(.ADDR_BASE(BASE), .ADDR_W(AW)) dut (
    .AXI_clk   (clk),
    .AXI_rst_n (rst_n),
    .AXI       (axi),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;
  int cyc = 0;
  int hold_until = 0;
  b_exp_t bq[$];
  r_exp_t rq[$];
  logic [31:0] mem [NW];
  bit          known [NW];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ready drivers: random backpressure, rready forced low on demand.
  always @(posedge clk) begin
    #1;
    cyc++;
    axi.bready = ($urandom_range(0, 3) != 0);
    if (cyc < hold_until) axi.rready = 1'b0;
    else axi.rready = ($urandom_range(0, 3) != 0);
  end

  bit r_stall, b_stall;
  logic [40:0] sv_r;
  logic [7:0]  sv_b;

  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (!rst_n) begin
      r_stall = 0;
      b_stall = 0;
    end else begin
      if (r_stall) begin
        chk("r_hold_valid", axi.rvalid, 1);
        chk("r_hold_fields", {axi.rdata, axi.rid, axi.rresp, axi.rlast}, sv_r);
      end
      if (b_stall) begin
        chk("b_hold_valid", axi.bvalid, 1);
        chk("b_hold_fields", {axi.bid, axi.bresp}, sv_b);
      end
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = bq.pop_front();
          chk("bid", axi.bid, be.id);
          chk("bresp", axi.bresp, be.resp);
        end
      end
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          if (re.chk) chk("rdata", axi.rdata, re.d);
          chk("rid", axi.rid, re.id);
          chk("rresp", axi.rresp, re.resp);
          chk("rlast", axi.rlast, re.last);
        end
      end
      r_stall = axi.rvalid && !axi.rready;
      b_stall = axi.bvalid && !axi.bready;
      sv_r = {axi.rdata, axi.rid, axi.rresp, axi.rlast};
      sv_b = {axi.bid, axi.bresp};
    end
  end

  function automatic bit legal(input logic [31:0] a, input int len,
                               input logic [1:0] bt, input logic [2:0] sz);
    bit ok;
    longint ba;
    ok = (bt == 2'b01) && (sz == 3'b010);
    for (int n = 0; n <= len; n++) begin
      ba = longint'(a) + 4 * n;
      if (ba < longint'(BASE) || ba >= longint'(BASE) + 4 * NW) ok = 0;
    end
    return ok;
  endfunction

  function automatic int widx(input logic [31:0] a, input int n);
    return int'((longint'(a) + 4 * n - longint'(BASE)) >>> 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      chk("drain_timeout", bq.size() + rq.size(), 0);
      bq.delete();
      rq.delete();
    end
    tick();
  endtask

  task automatic send_aw(input logic [31:0] a, input int len,
                         input logic [5:0] id, input logic [1:0] bt,
                         input logic [2:0] sz);
    int t = 0;
    tick();
    axi.awaddr = a; axi.awlen = 4'(len); axi.awid = id;
    axi.awburst = bt; axi.awsize = sz; axi.awvalid = 1'b1;
    @(negedge clk);
    while (!axi.awready && t < 100) begin @(negedge clk); t++; end
    if (!axi.awready) chk("aw_timeout", 0, 1);
    tick();
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                        input logic [5:0] id, input logic last);
    int t = 0;
    if ($urandom_range(0, 3) == 0) tick();
    axi.wdata = d; axi.wstrb = s; axi.wid = id;
    axi.wlast = last; axi.wvalid = 1'b1;
    @(negedge clk);
    while (!axi.wready && t < 100) begin @(negedge clk); t++; end
    if (!axi.wready) chk("w_timeout", 0, 1);
    tick();
    axi.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input int len,
                         input logic [5:0] id, input logic [1:0] bt,
                         input logic [2:0] sz);
    int t = 0;
    tick();
    axi.araddr = a; axi.arlen = 4'(len); axi.arid = id;
    axi.arburst = bt; axi.arsize = sz; axi.arvalid = 1'b1;
    @(negedge clk);
    while (!axi.arready && t < 100) begin @(negedge clk); t++; end
    if (!axi.arready) chk("ar_timeout", 0, 1);
    tick();
    axi.arvalid = 1'b0;
  endtask

  // Protocol-errored or abandoned bursts leave their words undefined.
  task automatic wr_burst(input logic [31:0] a, input int len,
                          input logic [5:0] id, input logic [1:0] bt,
                          input logic [2:0] sz, input int bad_last,
                          input bit bad_wid, input int nsend);
    bit ok, proto, good;
    int k;
    wait_idle();
    ok = legal(a, len, bt, sz);
    proto = (bad_last >= 0) || bad_wid || (nsend != len + 1);
    good = ok && !proto;
    if (nsend == len + 1) begin
      bq.push_back('{id, good ? 2'b00 : 2'b10});
      if (!good) exp_err++;
    end
    if (ok) begin
      for (int n = 0; n <= len; n++) begin
        k = widx(a, n);
        if (!good) known[k] = 0;
        else begin
          for (int b = 0; b < 4; b++)
            if (ws[n][b]) mem[k][8*b +: 8] = wd[n][8*b +: 8];
          known[k] = known[k] | (ws[n] == 4'hF);
        end
      end
    end
    send_aw(a, len, id, bt, sz);
    for (int n = 0; n < nsend; n++)
      send_w(wd[n], ws[n], (bad_wid && n == 1) ? id ^ 6'd1 : id,
             (bad_last >= 0) ? (n == bad_last) : (n == len));
  endtask

  task automatic rd_burst(input logic [31:0] a, input int len,
                          input logic [5:0] id, input logic [1:0] bt,
                          input logic [2:0] sz);
    bit ok;
    int k;
    wait_idle();
    ok = legal(a, len, bt, sz);
    if (!ok) exp_err++;
    for (int n = 0; n <= len; n++) begin
      k = ok ? widx(a, n) : 0;
      rq.push_back('{ok ? mem[k] : 32'h0, ok ? known[k] : 1'b1, id,
                     ok ? 2'b00 : 2'b10, n == len});
    end
    send_ar(a, len, id, bt, sz);
  endtask

  task automatic fill(input bit rnd);
    for (int n = 0; n < 16; n++) begin
      wd[n] = rnd ? $urandom : 32'(n);
      ws[n] = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  bt;
    logic [2:0]  sz;
    int len, sel;
    for (int i = 0; i < NW; i++) begin mem[i] = '0; known[i] = 0; end
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    axi.awaddr = 0; axi.awburst = 0; axi.awid = 0; axi.awlen = 0;
    axi.awsize = 0; axi.awcache = 0; axi.awlock = 0; axi.awprot = 0;
    axi.awqos = 0; axi.wdata = 0; axi.wstrb = 0; axi.wid = 0;
    axi.wlast = 0; axi.araddr = 0; axi.arburst = 0; axi.arid = 0;
    axi.arlen = 0; axi.arsize = 0; axi.arcache = 0; axi.arlock = 0;
    axi.arprot = 0; axi.arqos = 0; axi.bready = 0; axi.rready = 0;

    #23;
    chk("rst_readies", {axi.awready, axi.arready, axi.wready}, 0);
    chk("rst_valids", {axi.bvalid, axi.rvalid, axi.rlast}, 0);
    chk("rst_ids", {axi.bid, axi.bresp, axi.rid, axi.rresp}, 0);
    chk("rst_rdata", axi.rdata, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("awready_after_rst", axi.awready, 1);
    chk("arready_after_rst", axi.arready, 1);

    fill(0);
    wr_burst(BASE, 15, 6'h2A, INCR, SIZE4, -1, 0, 16);
    rd_burst(BASE, 15, 6'h15, INCR, SIZE4);

    fill(0);
    wd[0] = 32'hFFFF_FFFF;
    wr_burst(BASE + 32'h100, 0, 6'h01, INCR, SIZE4, -1, 0, 1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    wr_burst(BASE + 32'h100, 0, 6'h02, INCR, SIZE4, -1, 0, 1);
    rd_burst(BASE + 32'h100, 0, 6'h03, INCR, SIZE4);

    fill(1);
    wr_burst(BASE + 4 * NW, 3, 6'h04, INCR, SIZE4, -1, 0, 4);
    wait_idle();
    chk("err_cnt_oor_wr", err_cnt, 16'(exp_err));
    rd_burst(BASE + 4 * NW, 3, 6'h05, INCR, SIZE4);
    wait_idle();
    chk("err_cnt_oor_rd", err_cnt, 16'(exp_err));
    rd_burst(BASE, 3, 6'h06, INCR, SIZE4);

    wait_idle();
    hold_until = cyc + 12;
    rd_burst(BASE + 16, 3, 6'h07, INCR, SIZE4);

    fill(1);
    wr_burst(BASE + 32'h3C00, 7, 6'h08, INCR, SIZE4, 3, 0, 8);
    wr_burst(BASE + 32'h3C40, 3, 6'h09, INCR, SIZE4, -1, 1, 4);
    wr_burst(BASE + 32'h3C80, 1, 6'h0A, 2'b00, SIZE4, -1, 0, 2);
    wr_burst(BASE + 32'h3C80, 1, 6'h0B, INCR, 3'b001, -1, 0, 2);
    wr_burst(BASE + 4 * NW - 8, 3, 6'h0C, INCR, SIZE4, -1, 0, 4);
    rd_burst(BASE - 16, 3, 6'h0D, INCR, SIZE4);
    wait_idle();
    chk("err_cnt_proto", err_cnt, 16'(exp_err));

    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 15);
      a = BASE + 4 * $urandom_range(0, 48);
      bt = INCR; sz = SIZE4;
      sel = $urandom_range(0, 11);
      if (sel == 0) bt = 2'($urandom_range(2, 3));
      if (sel == 1) sz = 3'($urandom_range(0, 1));
      if (sel == 2) a = BASE + 4 * NW - 4 * $urandom_range(1, 3);
      fill(1);
      if ($urandom_range(0, 1) == 0)
        wr_burst(a, len, 6'($urandom), bt, sz, -1, 0, len + 1);
      else
        rd_burst(a, len, 6'($urandom), bt, sz);
    end
    wait_idle();
    chk("err_cnt_random", err_cnt, 16'(exp_err));

    fill(1);
    wr_burst(BASE + 32'h200, 7, 6'h11, INCR, SIZE4, -1, 0, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_readies", {axi.awready, axi.wready, axi.arready}, 0);
    chk("midrst_valids", {axi.bvalid, axi.rvalid}, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    exp_err = 0;
    bq.delete();
    rq.delete();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("awready_after_midrst", axi.awready, 1);
    fill(1);
    wr_burst(BASE + 32'h200, 7, 6'h12, INCR, SIZE4, -1, 0, 8);
    rd_burst(BASE + 32'h200, 7, 6'h13, INCR, SIZE4);
    wait_idle();
    chk("err_cnt_final", err_cnt, 16'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
